alu_result_tx: RTL and testbench



---
 rtl/alu_result_tx_pkg.sv | 24 ++
 rtl/alu_result_tx_if.sv | 9 +
 rtl/alu_result_tx_hex2ascii.sv | 22 ++
 rtl/alu_result_tx.sv | 122 ++++++++++++
 tb/tb_alu_result_tx.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_result_tx_pkg.sv
// Shared types and constants for the ALU result text formatter.
package alu_result_tx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_UA = 8'h41;
    localparam logic [7:0] ASC_LA = 8'h61;
    localparam logic [7:0] ASC_SP = 8'h20;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;

    localparam int LINE_LEN_CRLF   = 11;
    localparam int LINE_LEN_NOCRLF = 9;

    // Index of the final character of a line.
    function automatic logic [3:0] last_index(input bit send_crlf);
        return send_crlf ? 4'(LINE_LEN_CRLF - 1) : 4'(LINE_LEN_NOCRLF - 1);
    endfunction

endpackage

// File: rtl/alu_result_tx_if.sv
// Byte handshake between the formatter and the UART transmitter.
interface alu_result_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/alu_result_tx_hex2ascii.sv
// Converts one nibble to its ASCII hex digit.
module hex2ascii
    import alu_result_tx_pkg::*;
#(
    parameter bit UPPER_HEX = 1'b1
) (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    localparam logic [7:0] LETTER_BASE = UPPER_HEX ? ASC_UA : ASC_LA;

    // Digits map onto '0'..'9', values 10..15 onto the letter range.
    always_comb begin
        if (nibble < 4'd10) begin
            ascii = ASC_0 + {4'h0, nibble};
        end else begin
            ascii = LETTER_BASE + {4'h0, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/alu_result_tx.sv
// Formats a captured ALU result as a hex text line and streams it byte by byte.
module alu_result_tx
    import alu_result_tx_pkg::*;
#(
    parameter bit UPPER_HEX = 1'b1,
    parameter bit SEND_CRLF = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           result,
    input  logic                  alu_done,
    alu_result_tx_if.master       tx,
    output logic                  fmt_busy,
    output logic                  fmt_done,
    output logic                  overrun
);

    localparam logic [3:0] LAST_IDX = last_index(SEND_CRLF);

    state_t      state_reg;
    state_t      state_next;
    logic [3:0]  idx_reg;
    logic [31:0] hold_reg;
    logic        fmt_done_reg;
    logic        overrun_reg;

    logic        accept;
    logic        at_last;
    logic [3:0]  nibble;
    logic        use_hex;
    logic [7:0]  fixed_char;
    logic [7:0]  hex_char;

    assign accept  = (state_reg == SEND) && tx.tx_ready;
    assign at_last = (idx_reg == LAST_IDX);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: start on a result, finish once the last byte is taken.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (alu_done)         state_next = SEND;
            SEND: if (accept && at_last) state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    // Holding register, character index, completion pulse and sticky overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_reg     <= 32'h0;
            idx_reg      <= 4'd0;
            fmt_done_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            fmt_done_reg <= accept && at_last;
            if (state_reg == IDLE) begin
                if (alu_done) begin
                    hold_reg <= result;
                    idx_reg  <= 4'd0;
                end
            end else begin
                // A result arriving mid-line is dropped; the line keeps going.
                if (alu_done) begin
                    overrun_reg <= 1'b1;
                end
                if (accept && !at_last) begin
                    idx_reg <= idx_reg + 4'd1;
                end
            end
        end
    end

    // Character selection from the registered index: quotient, space, remainder, CR LF.
    always_comb begin
        nibble     = 4'h0;
        use_hex    = 1'b0;
        fixed_char = 8'h00;
        case (idx_reg)
            4'd0:  begin nibble = hold_reg[15:12]; use_hex = 1'b1; end
            4'd1:  begin nibble = hold_reg[11:8];  use_hex = 1'b1; end
            4'd2:  begin nibble = hold_reg[7:4];   use_hex = 1'b1; end
            4'd3:  begin nibble = hold_reg[3:0];   use_hex = 1'b1; end
            4'd4:  fixed_char = ASC_SP;
            4'd5:  begin nibble = hold_reg[31:28]; use_hex = 1'b1; end
            4'd6:  begin nibble = hold_reg[27:24]; use_hex = 1'b1; end
            4'd7:  begin nibble = hold_reg[23:20]; use_hex = 1'b1; end
            4'd8:  begin nibble = hold_reg[19:16]; use_hex = 1'b1; end
            4'd9:  fixed_char = ASC_CR;
            4'd10: fixed_char = ASC_LF;
            default: fixed_char = 8'h00;
        endcase
    end

    hex2ascii #(
        .UPPER_HEX(UPPER_HEX)
    ) u_hex2ascii (
        .nibble(nibble),
        .ascii (hex_char)
    );

    // Outputs decoded from registered state only; data reads zero when idle.
    always_comb begin
        tx.tx_valid = (state_reg == SEND);
        fmt_busy    = (state_reg == SEND);
        fmt_done    = fmt_done_reg;
        overrun     = overrun_reg;
        tx.tx_data  = 8'h00;
        if (state_reg == SEND) begin
            tx.tx_data = use_hex ? hex_char : fixed_char;
        end
    end

endmodule

// File: tb/tb_alu_result_tx.sv
// Directed bench for alu_result_tx: three instances cover the parameter variants.
module tb_alu_result_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] result = 32'h0;
    logic [2:0]  done = 3'b000;
    logic        tx_ready = 1'b0;
    logic [2:0]  busy;
    logic [2:0]  fdone;
    logic [2:0]  ovr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_result_tx_if bus_a ();
    alu_result_tx_if bus_b ();
    alu_result_tx_if bus_c ();

    assign bus_a.tx_ready = tx_ready;
    assign bus_b.tx_ready = tx_ready;
    assign bus_c.tx_ready = tx_ready;

    alu_result_tx #(.UPPER_HEX(1'b1), .SEND_CRLF(1'b1)) dut_a (
        .clk(clk), .rst(rst), .result(result), .alu_done(done[0]), .tx(bus_a),
        .fmt_busy(busy[0]), .fmt_done(fdone[0]), .overrun(ovr[0]));

    alu_result_tx #(.UPPER_HEX(1'b0), .SEND_CRLF(1'b1)) dut_b (
        .clk(clk), .rst(rst), .result(result), .alu_done(done[1]), .tx(bus_b),
        .fmt_busy(busy[1]), .fmt_done(fdone[1]), .overrun(ovr[1]));

    alu_result_tx #(.UPPER_HEX(1'b1), .SEND_CRLF(1'b0)) dut_c (
        .clk(clk), .rst(rst), .result(result), .alu_done(done[2]), .tx(bus_c),
        .fmt_busy(busy[2]), .fmt_done(fdone[2]), .overrun(ovr[2]));

    logic [7:0] o_data [3];
    logic [2:0] o_valid;
    assign o_data[0]  = bus_a.tx_data;
    assign o_data[1]  = bus_b.tx_data;
    assign o_data[2]  = bus_c.tx_data;
    assign o_valid[0] = bus_a.tx_valid;
    assign o_valid[1] = bus_b.tx_valid;
    assign o_valid[2] = bus_c.tx_valid;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called right after the capture edge; walks one line, optionally with
    // tx_ready toggling 1,0,0,1 and an extra alu_done injected at byte inject_at.
    task automatic run_line(input int d, input logic [7:0] exp [11], input int n,
                            input bit toggle, input int inject_at, input string tag);
        int k;
        int cyc;
        bit r;
        bit injected;
        k = 0;
        cyc = 0;
        injected = 1'b0;
        while (k < n && cyc < 100) begin
            r = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            tx_ready = r;
            if (!injected && k == inject_at) begin
                done[d] = 1'b1;
                result = 32'hFFFF_FFFF;
                injected = 1'b1;
            end
            chk($sformatf("%s valid c%0d", tag, cyc), o_valid[d], 1);
            chk($sformatf("%s busy c%0d", tag, cyc), busy[d], 1);
            chk($sformatf("%s byte%0d c%0d", tag, k, cyc), o_data[d], exp[k]);
            chk($sformatf("%s early done c%0d", tag, cyc), fdone[d], 0);
            step();
            done = 3'b000;
            if (r) k++;
            cyc++;
        end
        tx_ready = 1'b1;
        chk({tag, " bytes sent"}, k, n);
        chk({tag, " fmt_done"}, fdone[d], 1);
        chk({tag, " valid end"}, o_valid[d], 0);
        chk({tag, " busy end"}, busy[d], 0);
    endtask

    logic [7:0] e1  [11];
    logic [7:0] e2  [11];
    logic [7:0] e3  [11];
    logic [7:0] e4  [11];
    logic [7:0] e5  [11];
    logic [7:0] e6a [11];
    logic [7:0] e6b [11];

    initial begin
        e1  = '{8'h30, 8'h30, 8'h30, 8'h45, 8'h20, 8'h30, 8'h30, 8'h30, 8'h32, 8'h0D, 8'h0A};
        e2  = '{8'h30, 8'h30, 8'h66, 8'h66, 8'h20, 8'h61, 8'h62, 8'h63, 8'h64, 8'h0D, 8'h0A};
        e3  = '{8'h35, 8'h36, 8'h37, 8'h38, 8'h20, 8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
        e4  = '{8'h43, 8'h33, 8'h42, 8'h31, 8'h20, 8'h39, 8'h41, 8'h30, 8'h46, 8'h0D, 8'h0A};
        e5  = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h20, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
        e6a = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h20, 8'h42, 8'h45, 8'h45, 8'h46, 8'h00, 8'h00};
        e6b = '{8'h35, 8'h46, 8'h30, 8'h43, 8'h20, 8'h30, 8'h30, 8'h41, 8'h30, 8'h00, 8'h00};

        // Reset state
        step();
        step();
        chk("rst tx_data", o_data[0], 8'h00);
        chk("rst tx_valid", o_valid, 3'b000);
        chk("rst busy", busy, 3'b000);
        chk("rst fmt_done", fdone, 3'b000);
        chk("rst overrun", ovr, 3'b000);
        rst = 1'b0;
        tx_ready = 1'b1;
        step();
        chk("idle tx_data", o_data[0], 8'h00);

        // Line 1: uppercase, ready held high
        $display("txn: line 0002_000E upper, ready=1");
        result = 32'h0002_000E;
        done[0] = 1'b1;
        step();
        done = 3'b000;
        run_line(0, e1, 11, 1'b0, -1, "l1");
        step();
        chk("l1 done one cycle", fdone[0], 0);

        // Line 2: lowercase instance
        $display("txn: line ABCD_00FF lower, ready=1");
        result = 32'hABCD_00FF;
        done[1] = 1'b1;
        step();
        done = 3'b000;
        run_line(1, e2, 11, 1'b0, -1, "l2");
        step();
        chk("l2 idle other dut", o_valid[0], 0);

        // Line 3: tx_ready toggling
        $display("txn: line 1234_5678 upper, ready toggling");
        result = 32'h1234_5678;
        done[0] = 1'b1;
        step();
        done = 3'b000;
        run_line(0, e3, 11, 1'b1, -1, "l3");
        chk("l3 no overrun", ovr[0], 0);
        step();

        // Line 4: alu_done dropped during the 3rd byte
        $display("txn: line 9A0F_C3B1 with overrun at byte 2");
        result = 32'h9A0F_C3B1;
        done[0] = 1'b1;
        step();
        done = 3'b000;
        run_line(0, e4, 11, 1'b0, 2, "l4");
        chk("l4 overrun set", ovr[0], 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("l4 no 2nd line %0d", i), o_valid[0], 0);
            chk($sformatf("l4 overrun sticky %0d", i), ovr[0], 1);
        end

        // Line 5: reset mid-line after 5 bytes
        $display("txn: line 0002_000E aborted by rst after 5 bytes");
        result = 32'h0002_000E;
        done[0] = 1'b1;
        step();
        done = 3'b000;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("l5 byte%0d", i), o_data[0], e1[i]);
            step();
        end
        rst = 1'b1;
        #1;
        chk("l5 rst valid", o_valid[0], 0);
        chk("l5 rst busy", busy[0], 0);
        chk("l5 rst overrun", ovr[0], 0);
        chk("l5 rst data", o_data[0], 8'h00);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("l5 no fmt_done %0d", i), fdone[0], 0);
            chk($sformatf("l5 no tx %0d", i), o_valid[0], 0);
        end
        $display("txn: line 0000_0000 after reset");
        result = 32'h0;
        done[0] = 1'b1;
        step();
        done = 3'b000;
        run_line(0, e5, 11, 1'b0, -1, "l5z");
        step();

        // Lines 6a/6b: no CRLF, second alu_done in the fmt_done cycle
        $display("txn: line BEEF_1234 no crlf");
        result = 32'hBEEF_1234;
        done[2] = 1'b1;
        step();
        done = 3'b000;
        run_line(2, e6a, 9, 1'b0, -1, "l6a");
        $display("txn: line 00A0_5F0C no crlf, started in fmt_done cycle");
        result = 32'h00A0_5F0C;
        done[2] = 1'b1;
        step();
        done = 3'b000;
        run_line(2, e6b, 9, 1'b0, -1, "l6b");
        chk("l6 no overrun", ovr[2], 0);
        step();
        chk("l6b done one cycle", fdone[2], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
